pixel_window_buffer: RTL
========================

PIXEL_WINDOW_BUFFER -- requirements
Module: pixel_window_buffer

Interface
REQ-001 Parameter: MAX_WIDTH, 2500, maximum image width in pixels and line-buffer depth.
REQ-002 Port: clk  in  1  single system clock, all state on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle pulse that latches frame size and begins a frame.
REQ-005 Port: img_width  in  16  frame width in pixels, sampled on start.
REQ-006 Port: img_height  in  16  frame height in pixels, sampled on start.
REQ-007 Port: pix_valid  in  1  upstream fetch has a pixel on pix_data.
REQ-008 Port: pix_data  in  32  fetched word {R[31:24], G[23:16], B[15:8], unused[7:0]}.
REQ-009 Port: pix_ready  out  1  block accepts pix_data this cycle.
REQ-010 Port: win_valid  out  1  win_data holds a complete 3x3 window.
REQ-011 Port: win_data  out  72  nine 8-bit samples, row-major, top-left in [71:64], bottom-right in [7:0].
REQ-012 Port: win_ready  in  1  downstream edge kernel consumes the window.
REQ-013 Port: busy  out  1  frame in progress.
REQ-014 Port: done  out  1  one-cycle pulse at end of frame.
REQ-015 Port: err  out  1  frame size illegal, held until next accepted start or rst.

Function
REQ-016 The block SHALL implement states IDLE, ACTIVE, FINISH; IDLE->ACTIVE on start with legal size, IDLE->FINISH on start with illegal size, ACTIVE->FINISH when the last window is consumed, FINISH->IDLE unconditionally after one cycle.
REQ-017 Size SHALL be illegal when width<3, height<3 or width>MAX_WIDTH; no pixels are accepted for an illegal frame.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 Pixel transfer occurs when pix_valid and pix_ready are both 1; pix_ready = ACTIVE and (not win_valid or win_ready) and pixels remaining.
REQ-020 Each accepted pixel SHALL be reduced to an 8-bit sample per REQ-032, with pixels taken in raster order, column x 0..W-1, row y 0..H-1, x wrapping to 0 and y incrementing at x=W-1.
REQ-021 Two line buffers of MAX_WIDTH x 8 SHALL hold rows y-1 and y-2, indexed by x with read-before-write on the same address.
REQ-022 A 3x3 shift register SHALL shift one column per accepted pixel, taking {line2[x], line1[x], sample}.
REQ-023 win_valid SHALL assert the cycle after accepting a pixel with x>=2 and y>=2, and hold with win_data stable until win_ready.
REQ-024 Exactly (W-2)*(H-2) windows SHALL be emitted per legal frame, no windows straddling a row wrap.
REQ-025 Simultaneous window consumption and pixel acceptance SHALL be allowed (full throughput, one window per cycle).
REQ-026 done SHALL pulse in FINISH; busy SHALL be 1 in ACTIVE only.

Reset
REQ-027 On rst all outputs SHALL go to 0 immediately: pix_ready, win_valid, win_data, busy, done, err.
REQ-028 On rst the state SHALL return to IDLE and counters clear; line-buffer contents need not clear.
REQ-029 rst mid-frame SHALL abandon the frame; the next start begins a clean frame.

Configuration
REQ-030 Macro PWB_LUMA_EN SHALL select the sample reduction.
REQ-031 With PWB_LUMA_EN defined: sample = (R + 2G + B) >> 2 computed in 10 bits, truncated.
REQ-032 Without PWB_LUMA_EN: sample = G (pix_data[23:16]).

Verification
REQ-033 4x4 frame, pixel n has R=G=B=n, win_ready=1 -> 4 windows, first = {0,1,2,4,5,6,8,9,10}, last = {5,6,7,9,10,11,13,14,15}, done pulse once.
REQ-034 Same frame, win_ready=0 for 5 cycles after first window -> pix_ready=0, win_data held at first window, then remaining 3 windows in order.
REQ-035 start with width=2, height=10 -> err=1, done pulse next cycle, zero windows, pix_ready never 1.
REQ-036 rst asserted after 7 pixels of 4x4 frame -> all outputs 0 same cycle; new start with 3x3 frame -> exactly one window.
REQ-037 Pixel R=100, G=50, B=200 in 3x3 frame -> bottom-right sample 100 with PWB_LUMA_EN, 50 without.
REQ-038 start pulsed while busy with width=8 -> ignored, current 4x4 frame still yields exactly 4 windows.

Source files
------------

// File: rtl/pixel_window_buffer.sv
// 3x3 sliding-window generator over a raster pixel stream using two line buffers.
// Define PWB_LUMA_EN to reduce pixels to (R + 2G + B) / 4 instead of the green channel.
module pixel_window_buffer #(
    parameter int unsigned MAX_WIDTH = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] img_width,
    input  logic [15:0] img_height,
    input  logic        pix_valid,
    input  logic [31:0] pix_data,
    output logic        pix_ready,
    output logic        win_valid,
    output logic [71:0] win_data,
    input  logic        win_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned XW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StActive, StFinish} state_e;

    state_e      state_q, state_d;
    logic [15:0] w_q, w_d, h_q, h_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        pix_left_q, pix_left_d;
    logic        win_last_q, win_last_d;
    logic        win_valid_q, win_valid_d;
    logic        err_q, err_d;
    logic [71:0] win_q, win_d;

    logic [7:0]  line1 [MAX_WIDTH];
    logic [7:0]  line2 [MAX_WIDTH];
    logic [7:0]  l1_rd, l2_rd, sample;
    logic        accept, size_ok, row_end, last_pix;

`ifdef PWB_LUMA_EN
    logic [9:0] luma_sum;
    assign luma_sum = {2'b00, pix_data[31:24]} + {1'b0, pix_data[23:16], 1'b0}
                    + {2'b00, pix_data[15:8]};
    assign sample   = luma_sum[9:2];
    wire logic unused_bits = ^{pix_data[7:0], luma_sum[1:0]};
`else
    assign sample = pix_data[23:16];
    wire logic unused_bits = ^{pix_data[31:24], pix_data[15:0]};
`endif

    assign l1_rd     = line1[x_q[XW-1:0]];
    assign l2_rd     = line2[x_q[XW-1:0]];
    assign size_ok   = (img_width >= 16'd3) && (img_height >= 16'd3)
                    && (img_width <= 16'(MAX_WIDTH));
    assign row_end   = (x_q == w_q - 16'd1);
    assign last_pix  = row_end && (y_q == h_q - 16'd1);
    assign pix_ready = (state_q == StActive) && (!win_valid_q || win_ready) && pix_left_q;
    assign accept    = pix_ready && pix_valid;

    assign busy      = (state_q == StActive);
    assign done      = (state_q == StFinish);
    assign err       = err_q;
    assign win_valid = win_valid_q;
    assign win_data  = win_q;

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_left_d  = pix_left_q;
        win_last_d  = win_last_q;
        win_valid_d = win_valid_q;
        err_d       = err_q;
        win_d       = win_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    w_d         = img_width;
                    h_d         = img_height;
                    x_d         = '0;
                    y_d         = '0;
                    win_valid_d = 1'b0;
                    win_last_d  = 1'b0;
                    pix_left_d  = size_ok;
                    err_d       = !size_ok;
                    state_d     = size_ok ? StActive : StFinish;
                end
            end
            StActive: begin
                if (win_valid_q && win_ready) begin
                    win_valid_d = 1'b0;
                    if (win_last_q) state_d = StFinish;
                end
                if (accept) begin
                    // Each row of the window shifts left by one column; newest column on the right.
                    win_d       = {win_q[63:48], l2_rd, win_q[39:24], l1_rd, win_q[15:0], sample};
                    win_valid_d = (x_q >= 16'd2) && (y_q >= 16'd2);
                    win_last_d  = last_pix;
                    pix_left_d  = !last_pix;
                    if (row_end) begin
                        x_d = '0;
                        y_d = y_q + 16'd1;
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            w_q         <= '0;
            h_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_left_q  <= 1'b0;
            win_last_q  <= 1'b0;
            win_valid_q <= 1'b0;
            err_q       <= 1'b0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            h_q         <= h_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_left_q  <= pix_left_d;
            win_last_q  <= win_last_d;
            win_valid_q <= win_valid_d;
            err_q       <= err_d;
            win_q       <= win_d;
        end
    end

    // Line buffers carry no reset; rows are always rewritten before a window uses them.
    always_ff @(posedge clk) begin
        if (accept) begin
            line2[x_q[XW-1:0]] <= l1_rd;
            line1[x_q[XW-1:0]] <= sample;
        end
    end

endmodule
